// File: rtl/sram_like_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_like_arbiter
// Brief    : N-channel sram-like request arbiter with in-order response routing
// Revision : 1.0 - initial release
// ============================================================================
module sram_like_arbiter #(
    parameter int NUM_CH          = 2,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NUM_CH-1:0]          ch_req,
    input  logic [NUM_CH-1:0]          ch_wr,
    input  logic [2*NUM_CH-1:0]        ch_size,
    input  logic [NUM_CH*DATA_W/8-1:0] ch_wstrb,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
    input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
    input  logic [NUM_CH-1:0]          ch_cancel,
    output logic [NUM_CH-1:0]          ch_addr_ok,
    output logic [NUM_CH-1:0]          ch_data_ok,
    output logic [DATA_W-1:0]          ch_rdata,
    output logic                       mem_req,
    output logic                       mem_wr,
    output logic [1:0]                 mem_size,
    output logic [DATA_W/8-1:0]        mem_wstrb,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic                       mem_addr_ok,
    input  logic                       mem_data_ok,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic                       busy
);

    localparam int STRB_W = DATA_W / 8;
    localparam int ID_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [CNT_W-1:0] C_FULL     = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] C_LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [ID_W-1:0]  C_LAST_CH  = ID_W'(NUM_CH - 1);

    logic                       lock_q, lock_d;
    logic [ID_W-1:0]            lock_id_q, lock_id_d;
    logic                       cancel_lock_q, cancel_lock_d;
    logic [ID_W-1:0]            rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [ID_W-1:0]            fifo_id_q [MAX_OUTSTANDING];
    logic [ID_W-1:0]            fifo_id_d [MAX_OUTSTANDING];
    logic [MAX_OUTSTANDING-1:0] fifo_drop_q, fifo_drop_d;

    logic            w_rr_found;
    logic [ID_W-1:0] w_rr_id;
    logic [ID_W-1:0] w_grant_id;
    logic            w_can_grant;
    logic            w_accept;
    logic            w_push_drop;
    logic [ID_W-1:0] w_head_id;
    logic            w_head_drop;
    logic            w_pop;

    // Lowest requester at or above rr_ptr wins; otherwise wrap to lowest overall.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_id    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_req[i]) begin
                w_rr_found = 1'b1;
                w_rr_id    = ID_W'(i);
            end
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_req[i] && (ID_W'(i) >= rr_ptr_q)) begin
                w_rr_id = ID_W'(i);
            end
        end
    end

    assign w_grant_id  = lock_q ? lock_id_q : w_rr_id;
    assign w_can_grant = !lock_q && w_rr_found && (count_q < C_FULL);
    assign mem_req     = resetn & (lock_q | w_can_grant);
    assign w_accept    = mem_req & mem_addr_ok;
    assign w_push_drop = ch_cancel[w_grant_id] | (lock_q & cancel_lock_q);

    assign w_head_id   = fifo_id_q[rd_ptr_q];
    assign w_head_drop = fifo_drop_q[rd_ptr_q] | ch_cancel[w_head_id];
    assign w_pop       = mem_data_ok & (count_q != '0);

    assign ch_rdata = mem_rdata;
    assign busy     = (count_q != '0) | lock_q;

    always_comb begin
        mem_wr    = 1'b0;
        mem_size  = '0;
        mem_wstrb = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_grant_id == ID_W'(i)) begin
                mem_wr    = ch_wr[i];
                mem_size  = ch_size[i*2 +: 2];
                mem_wstrb = ch_wstrb[i*STRB_W +: STRB_W];
                mem_addr  = ch_addr[i*ADDR_W +: ADDR_W];
                mem_wdata = ch_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        ch_addr_ok             = '0;
        ch_addr_ok[w_grant_id] = w_accept;
        ch_data_ok             = '0;
        ch_data_ok[w_head_id]  = w_pop & ~w_head_drop;
    end

    always_comb begin
        lock_d        = lock_q;
        lock_id_d     = lock_id_q;
        cancel_lock_d = cancel_lock_q;
        rr_ptr_d      = rr_ptr_q;
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        fifo_id_d     = fifo_id_q;
        fifo_drop_d   = fifo_drop_q;

        for (int k = 0; k < MAX_OUTSTANDING; k++) begin
            if (ch_cancel[fifo_id_q[k]]) begin
                fifo_drop_d[k] = 1'b1;
            end
        end

        if (w_accept) begin
            fifo_id_d[wr_ptr_q]   = w_grant_id;
            fifo_drop_d[wr_ptr_q] = w_push_drop;
            wr_ptr_d      = (wr_ptr_q == C_LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
            rr_ptr_d      = (w_grant_id == C_LAST_CH) ? '0 : w_grant_id + ID_W'(1);
            lock_d        = 1'b0;
            cancel_lock_d = 1'b0;
        end else if (mem_req) begin
            // Stalled grant: hold the channel so its payload cannot change under the memory.
            lock_d        = 1'b1;
            lock_id_d     = w_grant_id;
            cancel_lock_d = (lock_q & cancel_lock_q) | ch_cancel[w_grant_id];
        end

        if (w_pop) begin
            rd_ptr_d = (rd_ptr_q == C_LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
        end

        case ({w_accept, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_q        <= 1'b0;
            lock_id_q     <= '0;
            cancel_lock_q <= 1'b0;
            rr_ptr_q      <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_drop_q   <= '0;
            for (int k = 0; k < MAX_OUTSTANDING; k++) begin
                fifo_id_q[k] <= '0;
            end
        end else begin
            lock_q        <= lock_d;
            lock_id_q     <= lock_id_d;
            cancel_lock_q <= cancel_lock_d;
            rr_ptr_q      <= rr_ptr_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_drop_q   <= fifo_drop_d;
            fifo_id_q     <= fifo_id_d;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (resetn && mem_data_ok) begin
            assert (count_q != '0)
                else $warning("sram_like_arbiter: mem_data_ok with nothing outstanding");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_like_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_like_arbiter
// Brief    : Directed self-checking bench for sram_like_arbiter (2 channels)
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_like_arbiter;

    localparam int NUM_CH = 2;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic                       clk;
    logic                       resetn;
    logic [NUM_CH-1:0]          ch_req;
    logic [NUM_CH-1:0]          ch_wr;
    logic [2*NUM_CH-1:0]        ch_size;
    logic [NUM_CH*DATA_W/8-1:0] ch_wstrb;
    logic [NUM_CH*ADDR_W-1:0]   ch_addr;
    logic [NUM_CH*DATA_W-1:0]   ch_wdata;
    logic [NUM_CH-1:0]          ch_cancel;
    logic [NUM_CH-1:0]          ch_addr_ok;
    logic [NUM_CH-1:0]          ch_data_ok;
    logic [DATA_W-1:0]          ch_rdata;
    logic                       mem_req;
    logic                       mem_wr;
    logic [1:0]                 mem_size;
    logic [DATA_W/8-1:0]        mem_wstrb;
    logic [ADDR_W-1:0]          mem_addr;
    logic [DATA_W-1:0]          mem_wdata;
    logic                       mem_addr_ok;
    logic                       mem_data_ok;
    logic [DATA_W-1:0]          mem_rdata;
    logic                       busy;

    int checks = 0;
    int errors = 0;

    sram_like_arbiter #(
        .NUM_CH          (NUM_CH),
        .ADDR_W          (ADDR_W),
        .DATA_W          (DATA_W),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .ch_req      (ch_req),
        .ch_wr       (ch_wr),
        .ch_size     (ch_size),
        .ch_wstrb    (ch_wstrb),
        .ch_addr     (ch_addr),
        .ch_wdata    (ch_wdata),
        .ch_cancel   (ch_cancel),
        .ch_addr_ok  (ch_addr_ok),
        .ch_data_ok  (ch_data_ok),
        .ch_rdata    (ch_rdata),
        .mem_req     (mem_req),
        .mem_wr      (mem_wr),
        .mem_size    (mem_size),
        .mem_wstrb   (mem_wstrb),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_addr_ok (mem_addr_ok),
        .mem_data_ok (mem_data_ok),
        .mem_rdata   (mem_rdata),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        ch_req      = '0;
        ch_cancel   = '0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 1'b0;
        cyc();
        cyc();
        resetn = 1'b1;
    endtask

    initial begin
        resetn    = 1'b0;
        idle_inputs();
        ch_wr     = '0;
        ch_size   = {2'd2, 2'd2};
        ch_wstrb  = '1;
        ch_addr   = '0;
        ch_wdata  = '0;
        mem_rdata = '0;

        // Reset state
        cyc();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_addr_ok", ch_addr_ok, 0);
        chk("rst_data_ok", ch_data_ok, 0);
        chk("rst_busy", busy, 0);
        resetn = 1'b1;

        // 1: single read on channel 0
        ch_addr[31:0] = 32'h1c00_0000;
        ch_req        = 2'b01;
        mem_addr_ok   = 1'b1;
        settle();
        chk("t1_mem_req", mem_req, 1);
        chk("t1_addr_ok", ch_addr_ok, 2'b01);
        chk("t1_mem_addr", mem_addr, 32'h1c00_0000);
        chk("t1_mem_wr", mem_wr, 0);
        cyc();
        ch_req      = '0;
        mem_addr_ok = 1'b0;
        settle();
        chk("t1_busy", busy, 1);
        chk("t1_no_data", ch_data_ok, 0);
        cyc();
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h1234_5678;
        settle();
        chk("t1_data_ok", ch_data_ok, 2'b01);
        chk("t1_rdata", ch_rdata, 32'h1234_5678);
        cyc();
        mem_data_ok = 1'b0;
        settle();
        chk("t1_idle", busy, 0);

        // 2 + 4: alternating grants until full, then no-bypass on pop
        do_reset();
        ch_addr     = {32'h0000_0200, 32'h0000_0100};
        ch_req      = 2'b11;
        mem_addr_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("t2_grant", ch_addr_ok, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("t2_addr", mem_addr, (k % 2 == 0) ? 32'h100 : 32'h200);
            cyc();
        end
        mem_addr_ok = 1'b0;
        settle();
        chk("t4_full_req", mem_req, 0);
        chk("t4_full_addr_ok", ch_addr_ok, 0);
        chk("t4_full_busy", busy, 1);
        mem_data_ok = 1'b1;
        settle();
        chk("t2_resp0", ch_data_ok, 2'b01);
        chk("t4_no_bypass", mem_req, 0);
        cyc();
        mem_data_ok = 1'b0;
        settle();
        chk("t4_req_after_pop", mem_req, 1);
        chk("t4_rr_addr", mem_addr, 32'h100);
        ch_req = '0;
        for (int k = 1; k < 4; k++) begin
            mem_data_ok = 1'b1;
            settle();
            chk("t2_resp", ch_data_ok, (k % 2 == 1) ? 2'b10 : 2'b01);
            cyc();
        end
        mem_data_ok = 1'b0;
        settle();
        chk("t2_idle", busy, 0);

        // 3: stalled grant on channel 1 holds its payload
        do_reset();
        ch_addr     = {32'h0000_00a1, 32'h0000_00a0};
        ch_wdata    = {32'h0000_00d1, 32'h0000_00d0};
        ch_wr       = 2'b10;
        ch_req      = 2'b10;
        mem_addr_ok = 1'b0;
        settle();
        chk("t3_req", mem_req, 1);
        chk("t3_addr0", mem_addr, 32'ha1);
        cyc();
        ch_req = 2'b11;
        for (int k = 0; k < 2; k++) begin
            settle();
            chk("t3_hold_addr", mem_addr, 32'ha1);
            chk("t3_hold_wdata", mem_wdata, 32'hd1);
            chk("t3_hold_wr", mem_wr, 1);
            chk("t3_hold_req", mem_req, 1);
            chk("t3_hold_no_ok", ch_addr_ok, 0);
            cyc();
        end
        mem_addr_ok = 1'b1;
        settle();
        chk("t3_accept", ch_addr_ok, 2'b10);
        chk("t3_accept_addr", mem_addr, 32'ha1);
        cyc();
        ch_req      = '0;
        ch_wr       = '0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        settle();
        chk("t3_resp", ch_data_ok, 2'b10);
        cyc();
        mem_data_ok = 1'b0;
        settle();
        chk("t3_idle", busy, 0);

        // 5: cancel channel 0 with 0,1,0 outstanding
        do_reset();
        mem_addr_ok = 1'b1;
        ch_req = 2'b01; settle(); chk("t5_acc0", ch_addr_ok, 2'b01); cyc();
        ch_req = 2'b10; settle(); chk("t5_acc1", ch_addr_ok, 2'b10); cyc();
        ch_req = 2'b01; settle(); chk("t5_acc2", ch_addr_ok, 2'b01); cyc();
        ch_req      = '0;
        mem_addr_ok = 1'b0;
        ch_cancel   = 2'b01;
        settle();
        chk("t5_busy", busy, 1);
        cyc();
        ch_cancel = '0;
        for (int k = 0; k < 3; k++) begin
            mem_data_ok = 1'b1;
            settle();
            chk("t5_resp", ch_data_ok, (k == 1) ? 2'b10 : 2'b00);
            cyc();
        end
        mem_data_ok = 1'b0;
        settle();
        chk("t5_idle", busy, 0);

        // Cancel in the same cycle as the accept
        ch_req      = 2'b01;
        mem_addr_ok = 1'b1;
        ch_cancel   = 2'b01;
        settle();
        chk("t5b_accept", ch_addr_ok, 2'b01);
        cyc();
        ch_req      = '0;
        ch_cancel   = '0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        settle();
        chk("t5b_dropped", ch_data_ok, 2'b00);
        cyc();
        mem_data_ok = 1'b0;
        settle();
        chk("t5b_idle", busy, 0);

        // Cancel while the channel holds a locked grant
        ch_req = 2'b10;
        settle();
        cyc();
        ch_cancel = 2'b10;
        settle();
        chk("t5c_lock_busy", busy, 1);
        cyc();
        ch_cancel   = '0;
        mem_addr_ok = 1'b1;
        settle();
        chk("t5c_accept", ch_addr_ok, 2'b10);
        cyc();
        ch_req      = '0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        settle();
        chk("t5c_dropped", ch_data_ok, 2'b00);
        cyc();
        mem_data_ok = 1'b0;
        settle();
        chk("t5c_idle", busy, 0);

        // Cancel in the same cycle as the head pops
        ch_req      = 2'b01;
        mem_addr_ok = 1'b1;
        settle();
        cyc();
        ch_req      = '0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        ch_cancel   = 2'b01;
        settle();
        chk("t5d_pop_cancel", ch_data_ok, 2'b00);
        cyc();
        mem_data_ok = 1'b0;
        ch_cancel   = '0;
        settle();
        chk("t5d_idle", busy, 0);

        // 6: reset mid-transaction with lock=1 and count=3
        do_reset();
        ch_req      = 2'b01;
        mem_addr_ok = 1'b1;
        cyc();
        cyc();
        cyc();
        mem_addr_ok = 1'b0;
        cyc();
        chk("t6_pre_busy", busy, 1);
        chk("t6_pre_req", mem_req, 1);
        resetn      = 1'b0;
        mem_data_ok = 1'b1;
        settle();
        chk("t6_rst_req", mem_req, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_data_ok", ch_data_ok, 0);
        cyc();
        resetn = 1'b1;
        ch_req = '0;
        settle();
        chk("t6_stray_data_ok", ch_data_ok, 0);
        cyc();
        mem_data_ok = 1'b0;
        settle();
        chk("t6_stray_busy", busy, 0);
        chk("t6_stray_req", mem_req, 0);
        ch_req      = 2'b01;
        mem_addr_ok = 1'b1;
        settle();
        chk("t6_after_accept", ch_addr_ok, 2'b01);
        cyc();
        ch_req      = '0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        settle();
        chk("t6_after_resp", ch_data_ok, 2'b01);
        cyc();
        mem_data_ok = 1'b0;
        settle();
        chk("t6_after_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
